// File: rtl/ibex_rf_pkg.sv
// Shared types and size helpers for the multi-port Ibex register file.
package ibex_rf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIPE = 2'd1,
    DONE = 2'd2
  } wipe_state_e;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 32'd4 : 32'd5;
  endfunction

  function automatic int unsigned rf_num_words(input bit rv32e);
    return 32'd1 << rf_addr_width(rv32e);
  endfunction

endpackage

// File: rtl/ibex_register_file_mp_wipe_ctrl.sv
// Secure-wipe sequencer: walks words 1..NumWords-1, then pulses done for one cycle.
module ibex_rf_wipe_ctrl
  import ibex_rf_pkg::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned NumWords  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wipe_req_i,
  output logic                 wipe_we,
  output logic [AddrWidth-1:0] wipe_addr,
  output logic                 busy,
  output logic                 done
);

  wipe_state_e          state_r, state_nxt_s;
  logic [AddrWidth-1:0] cnt_r, cnt_nxt_s;

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= AddrWidth'(1);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; exit is decided on the last word so cnt never wraps.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (wipe_req_i) begin
          state_nxt_s = WIPE;
          cnt_nxt_s   = AddrWidth'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WIPE: begin
        if (cnt_r == AddrWidth'(NumWords - 1)) begin
          state_nxt_s = DONE;
          cnt_nxt_s   = AddrWidth'(1);
        end else begin
          cnt_nxt_s   = cnt_r + AddrWidth'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = AddrWidth'(1);
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = AddrWidth'(1);
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    wipe_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wipe_addr = cnt_r;
    case (state_r)
      WIPE: begin
        wipe_we = 1'b1;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file with write bypass, write-conflict
// reporting and a run-time secure wipe of every stored word.
module ibex_register_file_mp
  import ibex_rf_pkg::*;
#(
  parameter bit                   RV32E         = 1'b0,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumReadPorts  = 2,
  parameter int unsigned          NumWritePorts = 2,
  parameter bit                   WriteBypass   = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic                              wipe_req_i,
  output logic                              wipe_busy_o,
  output logic                              wipe_done_o,
  output logic                              err_o
);

  localparam int unsigned AW = rf_addr_width(RV32E);
  localparam int unsigned NW = rf_num_words(RV32E);

  logic [AW-1:0]        waddr_s [NumWritePorts];
  logic [DataWidth-1:0] wdata_s [NumWritePorts];
  logic [DataWidth-1:0] mem_s   [NW];
  logic                 wipe_we_s, wipe_busy_s, wipe_done_s;
  logic [AW-1:0]        wipe_addr_s;
  logic                 err_s, err_r;

  ibex_rf_wipe_ctrl #(
    .AddrWidth(AW),
    .NumWords (NW)
  ) u_wipe_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wipe_req_i(wipe_req_i),
    .wipe_we   (wipe_we_s),
    .wipe_addr (wipe_addr_s),
    .busy      (wipe_busy_s),
    .done      (wipe_done_s)
  );

  for (genvar p = 0; p < NumWritePorts; p++) begin : g_wport
    assign waddr_s[p] = waddr_i[p*5 +: AW];
    assign wdata_s[p] = wdata_i[p*DataWidth +: DataWidth];
  end

  assign mem_s[0] = WordZeroVal;

  // Each word picks the highest-indexed matching port; the wipe overrides all ports.
  for (genvar w = 1; w < NW; w++) begin : g_word
    logic                 wr_en_s;
    logic [DataWidth-1:0] wr_data_s;
    logic [DataWidth-1:0] word_r;

    // Per-word write select.
    always_comb begin
      wr_en_s   = 1'b0;
      wr_data_s = WordZeroVal;
      if (wipe_we_s) begin
        wr_en_s = (wipe_addr_s == AW'(w));
      end else begin
        for (int p = 0; p < NumWritePorts; p++) begin
          wr_en_s   = wr_en_s | (we_i[p] & (waddr_s[p] == AW'(w)));
          wr_data_s = (we_i[p] && (waddr_s[p] == AW'(w))) ? wdata_s[p] : wr_data_s;
        end
      end
    end

    // Storage flop for this word.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        word_r <= WordZeroVal;
      end else if (wr_en_s) begin
        word_r <= wr_data_s;
      end else begin
        word_r <= word_r;
      end
    end

    assign mem_s[w] = word_r;
  end

  // Read ports: R0 and any read during a wipe return WordZeroVal.
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rport
    logic [AW-1:0]        raddr_s;
    logic [DataWidth-1:0] rd_s;

    assign raddr_s = raddr_i[p*5 +: AW];

    // Read mux with optional same-cycle write bypass.
    always_comb begin
      rd_s = WordZeroVal;
      if ((raddr_s == '0) || wipe_busy_s) begin
        rd_s = WordZeroVal;
      end else begin
        rd_s = mem_s[raddr_s];
        for (int q = 0; q < NumWritePorts; q++) begin
          rd_s = (WriteBypass && we_i[q] && (waddr_s[q] == raddr_s)) ? wdata_s[q] : rd_s;
        end
      end
    end

    assign rdata_o[p*DataWidth +: DataWidth] = rd_s;
  end

  // Error detection: same nonzero address on two ports, or any write during a wipe.
  always_comb begin
    err_s = 1'b0;
    if (wipe_busy_s) begin
      for (int p = 0; p < NumWritePorts; p++) begin
        err_s = err_s | (we_i[p] & (waddr_s[p] != '0));
      end
    end else begin
      for (int p = 0; p < NumWritePorts; p++) begin
        for (int q = p + 1; q < NumWritePorts; q++) begin
          err_s = err_s | (we_i[p] & we_i[q] & (waddr_s[p] == waddr_s[q]) & (waddr_s[p] != '0));
        end
      end
    end
  end

  // Registered error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign err_o       = err_r;
  assign wipe_busy_o = wipe_busy_s;
  assign wipe_done_o = wipe_done_s;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed self-checking bench: default instance, a no-bypass instance and an RV32E instance share stimulus.
module tb_ibex_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        wipe_req;

  logic [63:0] rdata, rdata_nb, rdata_e;
  logic        busy, busy_nb, busy_e;
  logic        done, done_nb, done_e;
  logic        err, err_nb, err_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_register_file_mp dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .wipe_req_i(wipe_req), .wipe_busy_o(busy),
    .wipe_done_o(done), .err_o(err)
  );

  ibex_register_file_mp #(.WriteBypass(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_nb), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .wipe_req_i(wipe_req), .wipe_busy_o(busy_nb),
    .wipe_done_o(done_nb), .err_o(err_nb)
  );

  ibex_register_file_mp #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_e), .waddr_i(waddr),
    .wdata_i(wdata), .we_i(we), .wipe_req_i(wipe_req), .wipe_busy_o(busy_e),
    .wipe_done_o(done_e), .err_o(err_e)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    we[p]           = en;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt, busy_cnt_e, done_cnt, done_cnt_e, done_at, done_at_e;

  initial begin
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0; wipe_req = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    // All addresses read WordZeroVal after reset.
    for (int a = 1; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      chk("rst_rd0", rdata[31:0], 0);
      chk("rst_rd1", rdata[63:32], 0);
    end
    chk("rst_err2", err, 0);

    // Bypass vs. no bypass on a single write.
    tick();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    raddr = {5'd0, 5'd5};
    #1;
    chk("byp_x5", rdata[31:0], 32'hDEADBEEF);
    chk("nobyp_x5_old", rdata_nb[31:0], 32'h0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("byp_x5_next", rdata[31:0], 32'hDEADBEEF);
    chk("nobyp_x5_next", rdata_nb[31:0], 32'hDEADBEEF);
    chk("x5_err", err, 0);

    // Two ports colliding on x7: port 1 wins and err pulses one cycle.
    set_wr(0, 1'b1, 5'd7, 32'h1111);
    set_wr(1, 1'b1, 5'd7, 32'h2222);
    raddr = {5'd0, 5'd7};
    #1;
    chk("coll_bypass", rdata[31:0], 32'h2222);
    chk("coll_err_pre", err, 0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("coll_err", err, 1);
    chk("coll_x7", rdata[31:0], 32'h2222);
    chk("coll_x7_nb", rdata_nb[31:0], 32'h2222);
    tick();
    chk("coll_err_clr", err, 0);

    // Both ports writing x0: dropped, no error.
    set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 1'b1, 5'd0, 32'hAAAA_AAAA);
    raddr = '0;
    #1;
    chk("x0_bypass", rdata[31:0], 0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_err", err, 0);
    chk("x0_rd", rdata[31:0], 0);

    // Fill x1..x31 with their index.
    for (int a = 1; a < 32; a++) begin
      set_wr(0, 1'b1, 5'(a), 32'(a));
      tick();
    end
    set_wr(0, 1'b0, 5'd0, 32'h0);
    for (int a = 1; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      chk("fill_rd", rdata[31:0], 32'(a));
    end

    // Wipe: busy cycles 1..31, done at 32, write in wipe cycle 10 dropped, write in DONE accepted.
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      raddr = {5'((cyc % 31) + 1), 5'((cyc % 31) + 1)};
      #1;
      chk("wipe_busy", busy, (cyc <= 31) ? 32'd1 : 32'd0);
      chk("wipe_done", done, (cyc == 32) ? 32'd1 : 32'd0);
      if (cyc <= 32) chk("wipe_rd", rdata[63:32], 0);
      if (cyc == 10) set_wr(0, 1'b1, 5'd3, 32'h3333);
      if (cyc == 11) begin
        set_wr(0, 1'b0, 5'd0, 32'h0);
        chk("wipe_wr_err", err, 1);
      end
      if (cyc == 12) chk("wipe_err_clr", err, 0);
      if (cyc == 32) set_wr(0, 1'b1, 5'd9, 32'h99);
      if (cyc == 33) begin
        set_wr(0, 1'b0, 5'd0, 32'h0);
        chk("done_wr_err", err, 0);
      end
      tick();
    end
    for (int a = 1; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      chk("post_wipe_rd", rdata[31:0], (a == 9) ? 32'h99 : 32'h0);
    end

    // Reset at wipe cycle 5 aborts; a fresh wipe then completes normally.
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_busy_e", busy_e, 0);
    chk("async_done", done, 0);
    chk("async_err", err, 0);
    raddr = {5'd9, 5'd9};
    #1;
    chk("async_rd", rdata[31:0], 0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_cnt += int'(done);
    end
    chk("no_done_after_rst", 32'(done_cnt), 0);

    busy_cnt = 0; busy_cnt_e = 0; done_cnt = 0; done_cnt_e = 0; done_at = 0; done_at_e = 0;
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      busy_cnt   += int'(busy);
      busy_cnt_e += int'(busy_e);
      if (done)   begin done_cnt++;   done_at = cyc;   end
      if (done_e) begin done_cnt_e++; done_at_e = cyc; end
      tick();
    end
    chk("rewipe_busy", 32'(busy_cnt), 31);
    chk("rewipe_done_cnt", 32'(done_cnt), 1);
    chk("rewipe_done_at", 32'(done_at), 32);
    chk("e_busy", 32'(busy_cnt_e), 15);
    chk("e_done_cnt", 32'(done_cnt_e), 1);
    chk("e_done_at", 32'(done_at_e), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_register_file_mp.md
# ibex_register_file_mp

Parametrised multi-port flip-flop register file for the Ibex core, generalising the single-write, dual-read register file to configurable read- and write-port counts. It adds three things:
- same-cycle write-to-read bypass;
- deterministic priority and error reporting on conflicting writes;
- a run-time secure-wipe state machine that walks every register to WordZeroVal.

It sits between the decode/ID stage (read ports) and the writeback stage(s) (write ports).

## Interface
Parameters:
- RV32E, 0: 1 gives 16 words (4-bit internal address), 0 gives 32 words.
- DataWidth, 32: register width in bits.
- NumReadPorts, 2: read port count, 1..4.
- NumWritePorts, 2: write port count, 1..2.
- WriteBypass, 1: 1 means a read that matches a same-cycle write returns that write's data.
- WordZeroVal, '0: value of R0, the reset value and the wipe value.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- raddr_i, input, NumReadPorts*5: read addresses; port p uses bits [5p+4:5p].
- rdata_o, output, NumReadPorts*DataWidth: read data; port p uses slice p.
- waddr_i, input, NumWritePorts*5: write addresses.
- wdata_i, input, NumWritePorts*DataWidth: write data.
- we_i, input, NumWritePorts: per-port write enable.
- wipe_req_i, input, 1: start a secure wipe (level, sampled only in IDLE).
- wipe_busy_o, output, 1: wipe in progress.
- wipe_done_o, output, 1: one-cycle pulse when a wipe completes.
- err_o, output, 1: registered pulse flagging a write conflict or a write attempted during a wipe.

## Operation
- Only the low ADDR_WIDTH address bits are used; upper bits are ignored (5 bits, or 4 when RV32E=1).
- R0 is not stored. Reads of address 0 return WordZeroVal. Writes to address 0 are dropped and are not errors.

Writes:
- A write lands at the clock edge after we_i is high.
- If several ports write the same nonzero address in one cycle, the highest-indexed port wins.
- That collision registers err_o=1 for the following cycle.

Reads:
- Reads are combinational from the array.
- With WriteBypass=1, a read whose address matches an enabled write returns that write's wdata, using the same priority rule. Address 0 is never bypassed.
- With WriteBypass=0, reads return the stored (old) value.

Wipe state machine (IDLE, WIPE, DONE; reset state IDLE):
- IDLE:
  - if wipe_req_i=1: go to WIPE; wipe counter = 1.
  - otherwise stay in IDLE.
- WIPE:
  - each cycle write mem[cnt]=WordZeroVal and increment cnt;
  - after writing the last word (NUM_WORDS-1), go to DONE.
- DONE: lasts one cycle, then returns to IDLE.

Behaviour during WIPE:
- All write ports are ignored. Any we_i with a nonzero address sets err_o next cycle.
- All read ports return WordZeroVal, so no partially wiped data leaks.
- wipe_req_i is ignored.

Behaviour in DONE: normal read/write behaviour resumes; wipe_req_i is ignored.

Outputs:
- wipe_busy_o = (state==WIPE).
- wipe_done_o = (state==DONE).
- err_o is a flop, cleared every cycle that has no error condition.

## Timing
- Reset (rst_i=1, asynchronous):
  - all stored words = WordZeroVal; state = IDLE; counter = 1;
  - err_o = 0, wipe_busy_o = 0, wipe_done_o = 0.
- Reset asserted mid-wipe aborts the wipe immediately; no wipe_done_o pulse is produced.
- Write latency is 1 cycle; read latency is 0 (combinational).
- err_o rises 1 cycle after the offending cycle.
- Wipe timing, with wipe_req_i sampled at edge 0:
  - wipe_busy_o is high for cycles 1..NUM_WORDS-1 (31 cycles, or 15 for RV32E);
  - wipe_done_o is high in cycle NUM_WORDS;
  - writes are accepted again from cycle NUM_WORDS.
- Counter wrap: the counter never exceeds NUM_WORDS-1. The exit to DONE is decided on cnt==NUM_WORDS-1, so there is no wrap to 0.

## Structure
- Shared package ibex_rf_pkg holds:
  - wipe_state_e (IDLE, WIPE, DONE), 2-bit enum;
  - localparam functions for ADDR_WIDTH/NUM_WORDS derived from RV32E.
- Sub-module ibex_rf_wipe_ctrl contains the FSM and counter.
  - Outputs: wipe_we, wipe_addr, busy, done.
  - The top merges wipe_we/wipe_addr as an overriding write port.
- Write-port priority selection and bypass muxing are generate loops in the top level.

## Test plan
- Reset, then read all 31 addresses on both ports -> every rdata_o = WordZeroVal; err_o=0.
- Write x5=0xDEADBEEF on port 0; in the same cycle read x5 with WriteBypass=1 -> 0xDEADBEEF immediately. With WriteBypass=0 -> 0 that cycle and 0xDEADBEEF the next.
- Ports 0 and 1 write x7 with 0x1111 and 0x2222 in the same cycle -> x7=0x2222, err_o=1 for exactly one cycle. Both ports writing x0 -> x0 reads WordZeroVal, err_o=0.
- Fill x1..x31 with their own index, pulse wipe_req_i:
  - wipe_busy_o is high 31 cycles;
  - rdata_o=WordZeroVal throughout;
  - wipe_done_o pulses once at cycle 32;
  - afterwards all registers read WordZeroVal.
- Issue we_i to x3 at wipe cycle 10 -> the write is dropped, err_o=1 the next cycle, x3 reads WordZeroVal after the wipe.
- Assert rst_i at wipe cycle 5 -> outputs clear asynchronously, state=IDLE, no wipe_done_o pulse; a new wipe_req_i after reset completes normally (RV32E=1: busy for 15 cycles).
